// File: rtl/painterengine_gpu_pkg.sv
// Shared definitions for the PainterEngine GPU pipeline stages.
//   FIX_FRAC / FIX_HALF : 16.16 fixed-point fraction width and rounding half.
//   ROT_LATENCY_DEF     : cycles through the CORDIC rotate stage.
//   PIX_COORD_W         : integer pixel coordinate width.
//   rot_scan_state_e    : rotate-scan sequencer states.
//   rot_cfg_t           : per-job configuration latched on start.
//   pix_req_t           : source-sample request sent to texture fetch.
package painterengine_gpu_pkg;

  localparam int          FIX_FRAC        = 16;
  localparam logic [31:0] FIX_HALF        = 32'h0000_8000;
  localparam int          ROT_LATENCY_DEF = 22;
  localparam int          PIX_COORD_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } rot_scan_state_e;

  typedef struct packed {
    logic [PIX_COORD_W-1:0] dst_w;
    logic [PIX_COORD_W-1:0] dst_h;
    logic [PIX_COORD_W-1:0] center_x;
    logic [PIX_COORD_W-1:0] center_y;
    logic [PIX_COORD_W-1:0] pivot_x;
    logic [PIX_COORD_W-1:0] pivot_y;
    logic [PIX_COORD_W-1:0] src_w;
    logic [PIX_COORD_W-1:0] src_h;
    logic [31:0]            angle;
  } rot_cfg_t;

  typedef struct packed {
    logic [PIX_COORD_W-1:0] dst_x;
    logic [PIX_COORD_W-1:0] dst_y;
    logic [PIX_COORD_W-1:0] src_x;
    logic [PIX_COORD_W-1:0] src_y;
    logic                   oob;
  } pix_req_t;

  // Sign-extend a signed pixel coordinate to 32 bits.
  function automatic logic [31:0] sext_coord(input logic [PIX_COORD_W-1:0] v);
    return {{(32-PIX_COORD_W){v[PIX_COORD_W-1]}}, v};
  endfunction

endpackage

// File: rtl/painterengine_gpu_sync_fifo.sv
// Synchronous FIFO with occupancy count, shared by GPU stages.
//   clk, rst          : clock, asynchronous active-high reset
//   wr_en, wr_data    : push (ignored when full)
//   rd_en, rd_data    : pop (ignored when empty); rd_data shows the head entry
//   count, empty, full: occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module painterengine_gpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_wr && !do_rd)      count_d = count_q + (AW+1)'(1);
    else if (!do_wr && do_rd) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until it has been written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/painterengine_gpu_rotate_scan.sv
// Rotate-stage sequencer and collector.
// Raster-scans the destination rectangle, issues one 16.16 coordinate pair
// per cycle to the CORDIC rotator (o_wire_rot_*), tracks the fixed rotator
// latency with a tag/valid shift register, converts results (i_wire_rot_*)
// to integer source samples and queues them for the texture fetch stream.
//   i_wire_start + config : job start, config latched on that cycle
//   o_wire_rot_x/y/angle  : rotator inputs;  i_wire_rot_x/y : rotator results
//   o_wire_pix_*          : pixel request stream; o_wire_busy, o_wire_done
// Stream handshake: a transfer happens on a clock edge where
// o_wire_pix_valid && i_wire_pix_ready; while valid is high and ready is low,
// valid and all data stay unchanged. Valid never depends on ready.
module painterengine_gpu_rotate_scan
  import painterengine_gpu_pkg::*;
#(
  parameter int ROT_LATENCY = ROT_LATENCY_DEF,
  parameter int FIFO_DEPTH  = 32,
  parameter int COORD_W     = PIX_COORD_W
) (
  input  logic               i_wire_clock,
  input  logic               i_wire_reset,
  input  logic               i_wire_start,
  input  logic [COORD_W-1:0] i_wire_dst_w,
  input  logic [COORD_W-1:0] i_wire_dst_h,
  input  logic [COORD_W-1:0] i_wire_center_x,
  input  logic [COORD_W-1:0] i_wire_center_y,
  input  logic [COORD_W-1:0] i_wire_pivot_x,
  input  logic [COORD_W-1:0] i_wire_pivot_y,
  input  logic [COORD_W-1:0] i_wire_src_w,
  input  logic [COORD_W-1:0] i_wire_src_h,
  input  logic [31:0]        i_wire_angle,
  output logic [31:0]        o_wire_rot_x,
  output logic [31:0]        o_wire_rot_y,
  output logic [31:0]        o_wire_rot_angle,
  input  logic [31:0]        i_wire_rot_x,
  input  logic [31:0]        i_wire_rot_y,
  output logic               o_wire_pix_valid,
  input  logic               i_wire_pix_ready,
  output logic [COORD_W-1:0] o_wire_pix_dst_x,
  output logic [COORD_W-1:0] o_wire_pix_dst_y,
  output logic [COORD_W-1:0] o_wire_pix_src_x,
  output logic [COORD_W-1:0] o_wire_pix_src_y,
  output logic               o_wire_pix_oob,
  output logic               o_wire_busy,
  output logic               o_wire_done
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 2;
  localparam int TAG_W = 1 + 2 * COORD_W;

  rot_scan_state_e    state_q, state_d;
  rot_cfg_t           cfg_q, cfg_d;
  logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
  logic [31:0]        rot_x_q, rot_x_d, rot_y_q, rot_y_d;
  logic [CW-1:0]      in_flight_q, in_flight_d;
  logic               busy_q, busy_d, done_q, done_d;
  // Entry layout {valid, col, row}; entry 0 is loaded on the same edge as
  // rot_x_q, so that register counts as the first of the ROT_LATENCY stages.
  logic [TAG_W-1:0]   sr_q [ROT_LATENCY];
  logic [TAG_W-1:0]   sr_in_d, sr_out;

  logic [AW:0]        fifo_count;
  logic               fifo_empty, fifo_full, fifo_pop;
  pix_req_t           wr_pix, head_pix;
  logic               issue, capture;
  logic [CW-1:0]      credit_sum;
  logic [31:0]        diff_x, diff_y;
  logic signed [31:0] sum_x, sum_y;

  always_comb begin
    sr_out     = sr_q[ROT_LATENCY-1];
    capture    = sr_out[TAG_W-1];
    // Every issued coordinate owns a FIFO slot until it is popped.
    credit_sum = in_flight_q + {1'b0, fifo_count};
    issue      = (state_q == ST_ISSUE) && (credit_sum < CW'(FIFO_DEPTH)) && !fifo_full;
    diff_x     = {{(32-COORD_W){1'b0}}, col_q} - sext_coord(cfg_q.center_x);
    diff_y     = {{(32-COORD_W){1'b0}}, row_q} - sext_coord(cfg_q.center_y);

    state_d = state_q;
    cfg_d   = cfg_q;
    col_d   = col_q;
    row_d   = row_q;
    rot_x_d = rot_x_q;
    rot_y_d = rot_y_q;
    sr_in_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_wire_start) begin
          cfg_d = '{dst_w: i_wire_dst_w, dst_h: i_wire_dst_h,
                    center_x: i_wire_center_x, center_y: i_wire_center_y,
                    pivot_x: i_wire_pivot_x, pivot_y: i_wire_pivot_y,
                    src_w: i_wire_src_w, src_h: i_wire_src_h, angle: i_wire_angle};
          col_d   = '0;
          row_d   = '0;
          state_d = (i_wire_dst_w == '0 || i_wire_dst_h == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          rot_x_d = diff_x << FIX_FRAC;
          rot_y_d = diff_y << FIX_FRAC;
          sr_in_d = {1'b1, col_q, row_q};
          if (col_q == cfg_q.dst_w - COORD_W'(1)) begin
            col_d = '0;
            if (row_q == cfg_q.dst_h - COORD_W'(1)) state_d = ST_DRAIN;
            else                                    row_d   = row_q + COORD_W'(1);
          end else begin
            col_d = col_q + COORD_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (in_flight_q == '0 && fifo_empty) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    in_flight_d = in_flight_q;
    if (issue && !capture)      in_flight_d = in_flight_q + CW'(1);
    else if (!issue && capture) in_flight_d = in_flight_q - CW'(1);

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);

    // Round to nearest integer, then translate into source space. Bounds use
    // the full-width sum so far-away samples cannot alias back in range.
    sum_x = ($signed(i_wire_rot_x + FIX_HALF) >>> FIX_FRAC) + $signed(sext_coord(cfg_q.pivot_x));
    sum_y = ($signed(i_wire_rot_y + FIX_HALF) >>> FIX_FRAC) + $signed(sext_coord(cfg_q.pivot_y));
    wr_pix.dst_x = sr_out[2*COORD_W-1:COORD_W];
    wr_pix.dst_y = sr_out[COORD_W-1:0];
    wr_pix.src_x = sum_x[COORD_W-1:0];
    wr_pix.src_y = sum_y[COORD_W-1:0];
    wr_pix.oob   = (sum_x < 0) || (sum_x >= $signed({{(32-COORD_W){1'b0}}, cfg_q.src_w})) ||
                   (sum_y < 0) || (sum_y >= $signed({{(32-COORD_W){1'b0}}, cfg_q.src_h}));
  end

  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      rot_x_q     <= '0;
      rot_y_q     <= '0;
      in_flight_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < ROT_LATENCY; i++) sr_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      col_q       <= col_d;
      row_q       <= row_d;
      rot_x_q     <= rot_x_d;
      rot_y_q     <= rot_y_d;
      in_flight_q <= in_flight_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sr_q[0]     <= sr_in_d;
      for (int i = 1; i < ROT_LATENCY; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  painterengine_gpu_sync_fifo #(
    .WIDTH ($bits(pix_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_wire_clock),
    .rst     (i_wire_reset),
    .wr_en   (capture),
    .wr_data (wr_pix),
    .rd_en   (fifo_pop),
    .rd_data (head_pix),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign fifo_pop         = !fifo_empty && i_wire_pix_ready;
  assign o_wire_rot_x     = rot_x_q;
  assign o_wire_rot_y     = rot_y_q;
  assign o_wire_rot_angle = cfg_q.angle;
  assign o_wire_pix_valid = !fifo_empty;
  // Data is zeroed when idle so the bus reads 0 out of reset.
  assign o_wire_pix_dst_x = fifo_empty ? '0 : head_pix.dst_x;
  assign o_wire_pix_dst_y = fifo_empty ? '0 : head_pix.dst_y;
  assign o_wire_pix_src_x = fifo_empty ? '0 : head_pix.src_x;
  assign o_wire_pix_src_y = fifo_empty ? '0 : head_pix.src_y;
  assign o_wire_pix_oob   = fifo_empty ? 1'b0 : head_pix.oob;
  assign o_wire_busy      = busy_q;
  assign o_wire_done      = done_q;

endmodule

// File: tb/tb_painterengine_gpu_rotate_scan.sv
module tb_painterengine_gpu_rotate_scan;

  localparam int          ROT_L = 22;
  localparam int          DEPTH = 32;
  localparam logic [31:0] ANG90 = 32'h005A_0000;

  // ---------------- clock / reset / DUT ----------------
  logic        clk, rst, start;
  logic [15:0] dst_w, dst_h, cen_x, cen_y, piv_x, piv_y, src_w, src_h;
  logic [31:0] angle, rot_x, rot_y, rot_angle, rin_x, rin_y;
  logic        pix_valid, pix_ready, pix_oob, busy, done;
  logic [15:0] pdx, pdy, psx, psy;
  logic [64:0] cur;

  painterengine_gpu_rotate_scan dut (
    .i_wire_clock     (clk),
    .i_wire_reset     (rst),
    .i_wire_start     (start),
    .i_wire_dst_w     (dst_w),
    .i_wire_dst_h     (dst_h),
    .i_wire_center_x  (cen_x),
    .i_wire_center_y  (cen_y),
    .i_wire_pivot_x   (piv_x),
    .i_wire_pivot_y   (piv_y),
    .i_wire_src_w     (src_w),
    .i_wire_src_h     (src_h),
    .i_wire_angle     (angle),
    .o_wire_rot_x     (rot_x),
    .o_wire_rot_y     (rot_y),
    .o_wire_rot_angle (rot_angle),
    .i_wire_rot_x     (rin_x),
    .i_wire_rot_y     (rin_y),
    .o_wire_pix_valid (pix_valid),
    .i_wire_pix_ready (pix_ready),
    .o_wire_pix_dst_x (pdx),
    .o_wire_pix_dst_y (pdy),
    .o_wire_pix_src_x (psx),
    .o_wire_pix_src_y (psy),
    .o_wire_pix_oob   (pix_oob),
    .o_wire_busy      (busy),
    .o_wire_done      (done)
  );

  assign cur = {pdx, pdy, psx, psy, pix_oob};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc_ctr = 0;
  initial forever begin
    @(posedge clk);
    cyc_ctr++;
  end

  // Rotator stand-in: exact rotation by 0 or 90 degrees. The DUT's output
  // register is the first stage, so ROT_L-1 more stages follow here.
  logic [31:0] rp_x [ROT_L-1];
  logic [31:0] rp_y [ROT_L-1];
  logic [31:0] m_x, m_y;
  always_comb begin
    if (rot_angle == ANG90) begin
      m_x = -rot_y;
      m_y = rot_x;
    end else begin
      m_x = rot_x;
      m_y = rot_y;
    end
  end
  always @(posedge clk) begin
    rp_x[0] <= m_x;
    rp_y[0] <= m_y;
    for (int i = 1; i < ROT_L - 1; i++) begin
      rp_x[i] <= rp_x[i-1];
      rp_y[i] <= rp_y[i-1];
    end
  end
  assign rin_x = rp_x[ROT_L-2];
  assign rin_y = rp_y[ROT_L-2];

  // ---------------- scoreboard state ----------------
  int          n_checks = 0, n_errors = 0;
  int          job_base = 0, first_lat = -1, rx_count = 0, max_credit = 0;
  logic        valid_seen = 1'b0, done_seen = 1'b0, prev_stall = 1'b0, busy_first = 1'b0;
  logic [64:0] prev_data = '0;
  logic [64:0] exp_q[$];

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops are sampled on the falling edge.
  initial forever begin
    logic [64:0] e;
    int          cs;
    @(negedge clk);
    cs = int'(dut.in_flight_q) + int'(dut.fifo_count);
    if (cs > max_credit) max_credit = cs;
    if (pix_valid) begin
      valid_seen = 1'b1;
      if (first_lat < 0) first_lat = cyc_ctr - job_base;
    end
    if (prev_stall) begin
      check("hold_valid", 96'(pix_valid), 96'(1));
      check("hold_data", 96'(cur), 96'(prev_data));
    end
    if (pix_valid && pix_ready) begin
      rx_count++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check("pix", 96'(cur), 96'(e));
    end
    prev_stall = pix_valid && !pix_ready;
    prev_data  = cur;
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input int w, h, cx, cy, px, py, sw, sh, input bit r90);
    int sx, sy;
    logic oob;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (r90) begin
          sx = -(r - cy) + px;
          sy = (c - cx) + py;
        end else begin
          sx = (c - cx) + px;
          sy = (r - cy) + py;
        end
        oob = (sx < 0) || (sx >= sw) || (sy < 0) || (sy >= sh);
        exp_q.push_back({16'(c), 16'(r), 16'(sx), 16'(sy), oob});
      end
    end
  endtask

  task automatic start_job(input int w, h, cx, cy, px, py, sw, sh, input logic [31:0] ang);
    @(posedge clk); #1;
    rx_count   = 0;
    first_lat  = -1;
    valid_seen = 1'b0;
    done_seen  = 1'b0;
    max_credit = 0;
    start = 1'b1;
    dst_w = 16'(w);  dst_h = 16'(h);
    cen_x = 16'(cx); cen_y = 16'(cy);
    piv_x = 16'(px); piv_y = 16'(py);
    src_w = 16'(sw); src_h = 16'(sh);
    angle = ang;
    @(posedge clk); #1;
    job_base = cyc_ctr - 1;
    start = 1'b0;
    // Scramble config after the start cycle; the job must use latched values.
    dst_w = 16'($urandom_range(0, 65535)); dst_h = 16'($urandom_range(0, 65535));
    cen_x = 16'($urandom_range(0, 65535)); piv_x = 16'($urandom_range(0, 65535));
    src_w = 16'($urandom_range(0, 65535)); angle = $urandom;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (i == 0) busy_first = busy;
      if (done) begin
        lat = cyc_ctr - job_base;
        break;
      end
    end
    done_seen = 1'b1;
  endtask

  task automatic drive_bp();
    for (int i = 1; i < 3000 && !done_seen; i++) begin
      if (i < 10)       pix_ready = 1'b1;
      else if (i <= 60) pix_ready = 1'b0;
      else              pix_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    pix_ready = 1'b1;
  endtask

  task automatic run_job(input string name, input int w, h, cx, cy, px, py, sw, sh,
                         input logic [31:0] ang, input int exp_done, input bit bp);
    int lat;
    push_exp(w, h, cx, cy, px, py, sw, sh, ang == ANG90);
    start_job(w, h, cx, cy, px, py, sw, sh, ang);
    if (bp) begin
      fork
        drive_bp();
        wait_done(3000, lat);
      join
    end else begin
      wait_done(300, lat);
    end
    if (exp_done >= 0) check({name, "_done_lat"}, 96'(lat), 96'(exp_done));
    else               check({name, "_done_seen"}, 96'(lat >= 0), 96'(1));
    check({name, "_busy_start"}, 96'(busy_first), 96'(1));
    @(negedge clk);
    check({name, "_done_pulse"}, 96'(done), 96'(0));
    check({name, "_busy_end"}, 96'(busy), 96'(0));
    check({name, "_npix"}, 96'(rx_count), 96'(w * h));
    check({name, "_exp_left"}, 96'(exp_q.size()), 96'(0));
    if (w * h > 0) check({name, "_first_lat"}, 96'(first_lat), 96'(ROT_L + 2));
    else           check({name, "_no_valid"}, 96'(valid_seen), 96'(0));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctl"}, 96'({pix_valid, busy, done}), 96'(0));
    check({name, "_pix"}, 96'(cur), 96'(0));
    check({name, "_rot_x"}, 96'(rot_x), 96'(0));
    check({name, "_rot_y"}, 96'(rot_y), 96'(0));
    check({name, "_rot_angle"}, 96'(rot_angle), 96'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; pix_ready = 1'b1; angle = '0;
    dst_w = '0; dst_h = '0; cen_x = '0; cen_y = '0;
    piv_x = '0; piv_y = '0; src_w = '0; src_h = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst0");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Done latency = ROT_L + 3 + pixel count when ready stays high.
    run_job("ident",  4, 2, 0, 0, 0, 0, 8, 8, 32'h0, 33, 1'b0);
    run_job("rot90",  3, 1, 0, 0, 4, 4, 8, 8, ANG90, 28, 1'b0);
    run_job("oob",    4, 1, 0, 0, 0, 0, 2, 2, 32'h0, 29, 1'b0);
    run_job("centre", 3, 2, 2, 1, 0, 0, 8, 8, 32'h0, 31, 1'b0);
    run_job("bp",    16, 4, 0, 0, 0, 0, 8, 8, 32'h0, -1, 1'b1);
    check("bp_credit_max", 96'(max_credit), 96'(DEPTH));
    run_job("w_zero", 0, 3, 0, 0, 0, 0, 8, 8, 32'h0, 1, 1'b0);
    run_job("h_zero", 3, 0, 0, 0, 0, 0, 8, 8, 32'h0, 1, 1'b0);

    // Abort a job after 10 issues; none of its pixels may ever appear.
    start_job(8, 8, 1, 1, 0, 0, 8, 8, ANG90);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    run_job("post_rst", 2, 2, 0, 0, 3, 3, 8, 8, 32'h0, 29, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/painterengine_gpu_rotate_scan.md
Name: painterengine_gpu_rotate_scan

Overview:
Upstream sequencer and downstream collector for the GPU CORDIC rotate stage. For each job it raster-scans a destination rectangle and issues one 16.16 coordinate pair per cycle into the rotate pipeline. It tracks the fixed pipeline latency and captures the rotated results into a credit-protected FIFO. It then emits integer source-sample requests over a valid/ready stream to the texture fetch stage.

Parameters:
ROT_LATENCY, 22, clock cycles from rotate-stage input to its output; must match the rotate stage.
FIFO_DEPTH, 32, result FIFO entries; power of two, must be >= ROT_LATENCY.
COORD_W, 16, width of integer pixel coordinates.

Ports:
i_wire_clock  in  1  clock
i_wire_reset  in  1  asynchronous, active-high reset
i_wire_start  in  1  one-cycle job start; ignored while busy
i_wire_dst_w, i_wire_dst_h  in  COORD_W  destination rectangle size, unsigned
i_wire_center_x, i_wire_center_y  in  COORD_W  signed rotation centre in destination space
i_wire_pivot_x, i_wire_pivot_y  in  COORD_W  signed source point mapped to the centre
i_wire_src_w, i_wire_src_h  in  COORD_W  source bounds, unsigned
i_wire_angle  in  32  signed 16.16 degrees, passed unchanged to the rotator
o_wire_rot_x, o_wire_rot_y  out  32  signed 16.16 coordinates to the rotator
o_wire_rot_angle  out  32  angle to the rotator
i_wire_rot_x, i_wire_rot_y  in  32  signed 16.16 results from the rotator
o_wire_pix_valid  out  1  output stream valid
i_wire_pix_ready  in  1  output stream ready
o_wire_pix_dst_x, o_wire_pix_dst_y  out  COORD_W  destination pixel
o_wire_pix_src_x, o_wire_pix_src_y  out  COORD_W  signed integer source sample
o_wire_pix_oob  out  1  source sample is outside [0,src_w) x [0,src_h)
o_wire_busy  out  1  job in progress
o_wire_done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset (async assert, sync deassert) sets the following to 0: all outputs, the FSM (IDLE), counters, FIFO pointers, the in-flight valid shift register and the credit count.
- Any job in progress at reset is discarded. Rotator results that arrive after reset are ignored because their valid bits were cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE -> ISSUE on start. All configuration inputs are latched on the start cycle; o_wire_busy=1 from the next cycle.
- If dst_w==0 or dst_h==0, IDLE -> DONE directly: no pixels are issued, done pulses 1 cycle after start.
- ISSUE:
  - On each cycle where in_flight + fifo_count < FIFO_DEPTH, drive rot_x = (col - center_x) << 16 and rot_y = (row - center_y) << 16, sign-extended to 32 bits.
  - Push a 1 plus {col,row} into a ROT_LATENCY-deep tag/valid shift register.
  - Advance col; at col == dst_w-1, wrap col to 0 and increment row.
  - After the issue of (dst_w-1, dst_h-1), go to DRAIN.
  - On cycles without an issue, push 0 into the valid shift register; rot_x and rot_y hold their values.
- o_wire_rot_angle = latched angle for the whole job, held constant.
- Capture: when the shift register output valid bit is 1, compute:
  - src_x = ((i_wire_rot_x + 0x8000) >>> 16) + pivot_x, truncated to COORD_W.
  - src_y is computed the same way from i_wire_rot_y and pivot_y.
  - oob = src_x < 0 | src_x >= src_w | src_y < 0 | src_y >= src_h. The comparison uses the full 32-bit sum before truncation.
  - Write {dst tag, src_x, src_y, oob} to the FIFO.
  - The FIFO never overflows, because credits are reserved at issue time.
- Credit accounting: in_flight increments on issue and decrements on capture. Simultaneous issue, capture and pop are all applied in the same cycle.
- Output stream:
  - o_wire_pix_valid = FIFO not empty.
  - A pop occurs when valid & ready.
  - Data is stable while valid & !ready.
  - Pixels leave in strict raster order, with no drops or duplicates.
- DRAIN -> DONE when in_flight==0, the FIFO is empty, and the pop of the last pixel has occurred.
- DONE: o_wire_done=1 for one cycle, then busy=0 and the FSM returns to IDLE. A start asserted in the DONE cycle is ignored.
- Throughput: one pixel per clock when ready is held high.
- First pixel latency: valid rises ROT_LATENCY+2 cycles after start (latch cycle, issue register, pipeline).

Decomposition:
- Shared package painterengine_gpu_pkg:
  - FIX_FRAC=16 and FIX_HALF=32'h8000.
  - Pixel request struct {dst_x, dst_y, src_x, src_y, oob}.
  - ROT_LATENCY default constant, shared with the rotate stage.
- One sub-module: painterengine_gpu_sync_fifo, a parameterised width/depth synchronous FIFO with count output, reused by later GPU stages.

Test Plan:
- Angle 0, dst 4x2, centre (0,0), pivot (0,0), src 8x8, ready=1.
  - Expected: 8 pixels in raster order with src=dst (tolerance ±1 for CORDIC error), oob=0.
  - Expected: done pulse, busy low.
- Angle 90<<16, dst 3x1, centre (0,0), pivot (4,4), src 8x8.
  - Expected: dst (2,0) -> src (4,6) ±1.
  - Expected: dst (0,0) -> src (4,4).
- Pivot (0,0), src 2x2, dst 4x1, angle 0.
  - Expected: dst x=2,3 -> oob=1.
  - Expected: dst x=0,1 -> oob=0.
- Backpressure: dst 16x4, ready low for cycles 10-60, then random toggling.
  - Expected: issue stalls when credits are exhausted (in_flight+count never exceeds FIFO_DEPTH).
  - Expected: all 64 pixels arrive in order with no duplicates.
  - Expected: data is held stable while valid & !ready.
- dst_w=0: start -> done pulses 1 cycle later, valid never rises. Repeat with dst_h=0.
- Reset during a job, after 10 issues: assert reset for 1 cycle, then start a new 2x2 job.
  - Expected: outputs are 0 during reset.
  - Expected: no stale pixels appear; exactly 4 new pixels are emitted.
